// File: rtl/dbi_encoder_pipe.sv
// dbi_encoder_pipe: registered, parametrised Data Bus Inversion encoder.
// The bus is split into LANES lanes of LANE_W bits. Each lane is inverted
// independently when its cost exceeds THRESH:
//   DC mode (mode=0): cost = number of zero bits in the lane.
//   AC mode (mode=1): cost = number of bit flips against the last word driven.
// A single output register stage with valid/ready handshake sits in front of
// the serializer. inv_cnt is a saturating count of inverted lanes.
module dbi_encoder_pipe #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  parameter int THRESH = LANE_W / 2,
  parameter int CNT_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      dbi_en,
  input  logic                      mode,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out_data,
  output logic [LANES-1:0]          out_dbi,
  input  logic                      idle_clr,
  input  logic                      stat_clr,
  output logic [CNT_W-1:0]          inv_cnt
);

  localparam int BUS_W  = LANES * LANE_W;
  localparam int COST_W = $clog2(LANE_W + 1);
  localparam int SUM_W  = $clog2(LANES + 1);
  localparam logic [COST_W-1:0] THRESH_C = COST_W'(THRESH);

  // Number of set bits in one lane.
  function automatic logic [COST_W-1:0] popcount(input logic [LANE_W-1:0] v);
    logic [COST_W-1:0] cnt;
    cnt = {COST_W{1'b0}};
    for (int i = 0; i < LANE_W; i++) begin
      cnt = cnt + COST_W'(v[i]);
    end
    return cnt;
  endfunction

  logic [BUS_W-1:0]  prev_r;
  logic [BUS_W-1:0]  out_data_r;
  logic [LANES-1:0]  out_dbi_r;
  logic              out_valid_r;
  logic [CNT_W-1:0]  inv_cnt_r;

  logic [BUS_W-1:0]  enc_s;
  logic [LANES-1:0]  inv_s;
  logic [SUM_W-1:0]  sum_s;
  logic [CNT_W:0]    sat_sum_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              accept_s;

  // The output register can take a new beat when empty or draining this cycle.
  assign in_ready = !out_valid_r || out_ready;
  assign accept_s = in_valid && in_ready;

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_dbi   = out_dbi_r;
  assign inv_cnt   = inv_cnt_r;

  // Per-lane cost, inversion decision, encoded word and inverted-lane sum.
  always_comb begin
    logic [LANE_W-1:0] lane_d_v;
    logic [LANE_W-1:0] lane_p_v;
    logic [COST_W-1:0] cost_v;
    enc_s = {BUS_W{1'b0}};
    inv_s = {LANES{1'b0}};
    sum_s = {SUM_W{1'b0}};
    for (int k = 0; k < LANES; k++) begin
      lane_d_v = in_data[k*LANE_W +: LANE_W];
      lane_p_v = prev_r[k*LANE_W +: LANE_W];
      if (mode) begin
        cost_v = popcount(lane_d_v ^ lane_p_v);
      end else begin
        cost_v = popcount(~lane_d_v);
      end
      // A tie (cost == THRESH) keeps the data as is.
      if (dbi_en && (cost_v > THRESH_C)) begin
        inv_s[k] = 1'b1;
        enc_s[k*LANE_W +: LANE_W] = ~lane_d_v;
      end else begin
        inv_s[k] = 1'b0;
        enc_s[k*LANE_W +: LANE_W] = lane_d_v;
      end
      sum_s = sum_s + SUM_W'(inv_s[k]);
    end
  end

  // Saturating add of this beat's inverted-lane count.
  always_comb begin
    sat_sum_s = {1'b0, inv_cnt_r} + (CNT_W+1)'(sum_s);
    if (sat_sum_s[CNT_W]) begin
      cnt_next_s = {CNT_W{1'b1}};
    end else begin
      cnt_next_s = sat_sum_s[CNT_W-1:0];
    end
  end

  // Output stage: load on accept, drop valid once drained, hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_data_r  <= {BUS_W{1'b0}};
      out_dbi_r   <= {LANES{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      out_data_r  <= enc_s;
      out_dbi_r   <= inv_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // AC history: follows the word actually driven; idle returns it to all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= {BUS_W{1'b1}};
    end else if (accept_s) begin
      prev_r <= enc_s;
    end else if (idle_clr) begin
      prev_r <= {BUS_W{1'b1}};
    end
  end

  // Inversion statistics; a clear overrides a beat accepted in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inv_cnt_r <= {CNT_W{1'b0}};
    end else if (stat_clr) begin
      inv_cnt_r <= {CNT_W{1'b0}};
    end else if (accept_s) begin
      inv_cnt_r <= cnt_next_s;
    end
  end

endmodule

// File: tb/tb_dbi_encoder_pipe.sv
// Testbench for dbi_encoder_pipe (LANES=4, LANE_W=8, CNT_W=4).
// Stimulus pushes hand-computed expected beats into a queue when a beat is
// accepted; a monitor pops and compares on every output transfer.
module tb_dbi_encoder_pipe;

  logic        clk;
  logic        rst_n;
  logic        dbi_en;
  logic        mode;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_dbi;
  logic        idle_clr;
  logic        stat_clr;
  logic [3:0]  inv_cnt;

  int checks;
  int fails;
  int xfers;
  logic [35:0] exp_q[$];

  dbi_encoder_pipe #(.LANES(4), .LANE_W(8), .THRESH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .dbi_en(dbi_en), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_dbi(out_dbi), .idle_clr(idle_clr), .stat_clr(stat_clr),
    .inv_cnt(inv_cnt)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: on every transfer compare against the oldest expected beat.
  always @(negedge clk) begin
    logic [35:0] e;
    if (rst_n && out_valid && out_ready) begin
      checks++;
      xfers++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: got data=%h dbi=%b, required no beat", out_data, out_dbi);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e[35:4] || out_dbi !== e[3:0]) begin
          fails++;
          $display("FAIL beat: got data=%h dbi=%b, required data=%h dbi=%b",
                   out_data, out_dbi, e[35:4], e[3:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Offer one beat; record the expected encoding once it is accepted.
  task automatic send_beat(input logic [31:0] d, input logic m, input logic en,
                           input logic [31:0] ed, input logic [3:0] edbi,
                           output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    in_data = d;
    mode = m;
    dbi_en = en;
    in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
    end
    if (!ok) begin
      checks++;
      fails++;
      $display("FAIL accept_timeout: got in_ready=0 for 50 cycles, required 1");
    end else begin
      exp_q.push_back({ed, edbi});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] st_din [10];
  logic [31:0] st_dout[10];
  logic [3:0]  st_dbi [10];
  int w;
  int wsum;

  initial begin
    checks = 0; fails = 0; xfers = 0;
    rst_n = 1'b0; dbi_en = 1'b1; mode = 1'b0; in_valid = 1'b0;
    in_data = 32'h0; out_ready = 1'b1; idle_clr = 1'b0; stat_clr = 1'b0;
    st_din[0] = 32'h00000000; st_dout[0] = 32'hFFFFFFFF; st_dbi[0] = 4'b1111;
    st_din[1] = 32'hFFFFFFFF; st_dout[1] = 32'hFFFFFFFF; st_dbi[1] = 4'b0000;
    st_din[2] = 32'h0F0F0F0F; st_dout[2] = 32'h0F0F0F0F; st_dbi[2] = 4'b0000;
    st_din[3] = 32'h01020304; st_dout[3] = 32'hFEFDFCFB; st_dbi[3] = 4'b1111;
    st_din[4] = 32'h12345678; st_dout[4] = 32'hEDCB5678; st_dbi[4] = 4'b1100;
    st_din[5] = 32'hAAAA5555; st_dout[5] = 32'hAAAA5555; st_dbi[5] = 4'b0000;
    st_din[6] = 32'h80FF7F00; st_dout[6] = 32'h7FFF7FFF; st_dbi[6] = 4'b1001;
    st_din[7] = 32'hC0E0F0F8; st_dout[7] = 32'h3F1FF0F8; st_dbi[7] = 4'b1100;
    st_din[8] = 32'h00FF00FF; st_dout[8] = 32'hFFFFFFFF; st_dbi[8] = 4'b1010;
    st_din[9] = 32'h3C3C3C3C; st_dout[9] = 32'h3C3C3C3C; st_dbi[9] = 4'b0000;

    // Reset state
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_out_dbi", {28'd0, out_dbi}, 32'd0);
    check("rst_inv_cnt", {28'd0, inv_cnt}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: DC; lane 2 (0x0F) ties and lane 1 (0x1F) has 3 zeros: only lane 3 inverts
    send_beat(32'h000F1FFF, 1'b0, 1'b1, 32'hFF0F1FFF, 4'b1000, w);
    check("t1_inv_cnt", {28'd0, inv_cnt}, 32'd1);
    idle(2);

    // 2: AC after reset
    do_reset();
    send_beat(32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 4'b1111, w);
    check("t2_inv_cnt_a", {28'd0, inv_cnt}, 32'd4);
    send_beat(32'hFFFF0000, 1'b1, 1'b1, 32'hFFFFFFFF, 4'b0011, w);
    check("t2_inv_cnt_b", {28'd0, inv_cnt}, 32'd6);
    idle(2);

    // 3: backpressure then a 10-beat stream
    xfers = 0;
    out_ready = 1'b0;
    send_beat(st_din[0], 1'b0, 1'b1, st_dout[0], st_dbi[0], w);
    in_data = st_din[1]; mode = 1'b0; dbi_en = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("t3_stall_valid", {31'd0, out_valid}, 32'd1);
      check("t3_stall_data", out_data, st_dout[0]);
      check("t3_stall_dbi", {28'd0, out_dbi}, {28'd0, st_dbi[0]});
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wsum = 0;
    for (int i = 1; i < 10; i++) begin
      send_beat(st_din[i], 1'b0, 1'b1, st_dout[i], st_dbi[i], w);
      wsum += w;
    end
    check("t3_stream_waits", wsum, 32'd0);
    idle(3);
    check("t3_xfers", xfers, 32'd10);

    // 4: idle_clr alone and together with a beat (AC)
    do_reset();
    send_beat(32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 4'b1111, w);
    send_beat(32'h0F0F0F0F, 1'b1, 1'b1, 32'h0F0F0F0F, 4'b0000, w);
    idle_clr = 1'b1;
    idle(1);
    idle_clr = 1'b0;
    send_beat(32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 4'b1111, w);
    idle_clr = 1'b1;
    send_beat(32'h0F0F0F0F, 1'b1, 1'b1, 32'h0F0F0F0F, 4'b0000, w);
    idle_clr = 1'b0;
    send_beat(32'h00000000, 1'b1, 1'b1, 32'h00000000, 4'b0000, w);
    idle(2);

    // 5: saturation at 15 and clear winning over a beat
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send_beat(32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1111, w);
      check("t5_inv_cnt", {28'd0, inv_cnt}, (i < 3) ? 32'(4 * (i + 1)) : 32'd15);
    end
    stat_clr = 1'b1;
    send_beat(32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1111, w);
    stat_clr = 1'b0;
    check("t5_clr", {28'd0, inv_cnt}, 32'd0);

    // 6: passthrough, then reset during a stall
    send_beat(32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1111, w);
    check("t6_cnt_pre", {28'd0, inv_cnt}, 32'd4);
    send_beat(32'h00000000, 1'b0, 1'b0, 32'h00000000, 4'b0000, w);
    send_beat(32'h12345678, 1'b1, 1'b0, 32'h12345678, 4'b0000, w);
    check("t6_cnt_pass", {28'd0, inv_cnt}, 32'd4);
    idle(2);
    out_ready = 1'b0;
    send_beat(32'h00000000, 1'b0, 1'b1, 32'hFFFFFFFF, 4'b1111, w);
    @(negedge clk);
    check("t6_stalled_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    check("t6_rst_cnt", {28'd0, inv_cnt}, 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    // History is back to all ones after reset
    send_beat(32'h00000000, 1'b1, 1'b1, 32'hFFFFFFFF, 4'b1111, w);
    idle(3);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
